// File: rtl/pipe_reg.sv
// pipe_reg
//   Elastic register pipeline: DEPTH stages of WIDTH-bit data, each with its
//   own valid bit, under a valid/ready handshake. Stalls collapse bubbles
//   toward the output, and a data register only loads when it takes a real
//   word, so unknown input data on idle cycles never reaches out_data.
//
// Parameters
//   WIDTH      data width in bits (>=1)
//   DEPTH      number of register stages (>=1)
//   RESET_VAL  value loaded into every data register on reset/flush
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset (dominates flush)
//   flush      synchronous clear of all stage valids; no input taken that cycle
//   in_valid   upstream word present
//   in_data    upstream word
//   in_ready   stage 0 can take a word this cycle
//   out_valid  last stage holds a word
//   out_data   last stage data
//   out_ready  downstream accepts this cycle
//   occupancy  registered count of valid stages

module pipe_reg #(
  parameter int              WIDTH     = 8,
  parameter int              DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [OW-1:0]    occ_q;

  // free[i] means slot i can accept a word this cycle; free[DEPTH] is the
  // downstream consumer.
  logic [DEPTH:0]   free;
  logic [DEPTH-1:0] move;
  logic [DEPTH-1:0] load;
  logic [WIDTH-1:0] src [DEPTH];
  logic             in_xfer;
  logic             out_xfer;

  // Walk from the output back to the input: a stage moves when it holds a
  // word and the slot ahead is empty or itself moving. This ripple is what
  // lets a stall collapse bubbles instead of freezing the whole pipe.
  always_comb begin
    free        = '0;
    move        = '0;
    free[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      move[i] = valid_q[i] && free[i+1];
      free[i] = !valid_q[i] || move[i];
    end
  end

  assign in_ready = free[0] && !flush && !reset;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = move[DEPTH-1];

  // Each stage loads from the one behind it when that one moves; stage 0
  // loads from the input on an accepted transfer.
  always_comb begin
    load    = '0;
    load[0] = in_xfer;
    src[0]  = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      load[i] = move[i-1];
      src[i]  = data_q[i-1];
    end
  end

  // Stage registers. A stage stays valid if it took a new word or held one
  // that could not move; data only changes on a load so idle cycles leave it
  // untouched.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VAL;
      end
    end else begin
      occ_q <= occ_q + OW'(in_xfer) - OW'(out_xfer);
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= load[i] || (valid_q[i] && !move[i]);
        if (load[i]) begin
          data_q[i] <= src[i];
        end
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg
//   Self-checking bench for pipe_reg (WIDTH=8, DEPTH=3, non-zero RESET_VAL).
//   A negedge monitor keeps a queue of accepted words and an occupancy model;
//   directed sequences check reset, latency, backpressure, X gaps and flush,
//   followed by a long random handshake run.

module tb_pipe_reg;

  localparam int         WIDTH = 8;
  localparam int         DEPTH = 3;
  localparam logic [7:0] RST   = 8'hC3;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [1:0] occupancy;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] expq[$];
  int         model_occ = 0;
  bit         mon_en = 1'b0;

  pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RST)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    step();
  endtask

  // A word offered with in_ready high must have a known valid bit.
  always @(posedge clk) begin
    if (reset === 1'b0 && in_ready === 1'b1) begin
      assert (!$isunknown(in_valid)) else $error("[TB] in_valid unknown while in_ready high");
    end
  end

  // Scoreboard monitor: compare delivered words and occupancy against the
  // model, then fold this cycle's transfers into the model.
  always @(negedge clk) begin
    if (mon_en) begin
      bit ix, ox;
      checkOutput("occupancy", 32'(occupancy), 32'(model_occ));
      ox = (out_valid === 1'b1) && (out_ready === 1'b1);
      ix = (in_valid === 1'b1) && (in_ready === 1'b1);
      if (ox) begin
        if (expq.size() == 0) begin
          checkOutput("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          checkOutput("out_data", 32'(out_data), 32'(expq.pop_front()));
        end
      end
      if (out_ready && !flush && !reset) begin
        checkOutput("in_ready_free", 32'(in_ready), 32'd1);
      end
      if (model_occ == DEPTH && !out_ready) begin
        checkOutput("in_ready_full", 32'(in_ready), 32'd0);
      end
      if (ix) expq.push_back(in_data);
      if (reset || flush) begin
        expq.delete();
        model_occ = 0;
      end else begin
        model_occ = model_occ + int'(ix) - int'(ox);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    out_ready = 1'b1;

    // Reset held with a word offered: nothing may be accepted or shown.
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_data", 32'(out_data), 32'(RST));
      checkOutput("rst_occ", 32'(occupancy), 32'd0);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    mon_en   = 1'b1;
    step();

    // Streaming: first word shows up after the third edge, then one per cycle.
    $display("[TB] streaming");
    applyStimulus(1'b1, 8'h11, 1'b1, 1'b0);
    checkOutput("lat_e1", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, 8'h22, 1'b1, 1'b0);
    checkOutput("lat_e2", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, 8'h33, 1'b1, 1'b0);
    checkOutput("lat_e3_v", 32'(out_valid), 32'd1);
    checkOutput("lat_e3_d", 32'(out_data), 32'h11);
    applyStimulus(1'b1, 8'h44, 1'b1, 1'b0);
    checkOutput("stream_d2", 32'(out_data), 32'h22);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("stream_d3", 32'(out_data), 32'h33);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("stream_d4", 32'(out_data), 32'h44);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("stream_empty", 32'(out_valid), 32'd0);

    // Backpressure: three words fill the pipe, the fourth waits.
    $display("[TB] backpressure");
    applyStimulus(1'b1, 8'hA0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hA2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'hA3, 1'b0, 1'b0);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_occ", 32'(occupancy), 32'd3);
      checkOutput("bp_hold", 32'(out_data), 32'hA0);
      checkOutput("bp_valid", 32'(out_valid), 32'd1);
    end
    applyStimulus(1'b1, 8'hA3, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // X gaps: unknown data on idle cycles must never reach the output.
    $display("[TB] x-gap");
    for (int i = 0; i < 40; i++) begin
      if ((i % 4) < 2) applyStimulus(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
      else             applyStimulus(1'b0, 8'hxx, 1'b1, 1'b0);
    end
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("xgap_drained", 32'(expq.size()), 32'd0);

    // Flush while stalled and full, with a word offered on the flush cycle.
    $display("[TB] flush");
    applyStimulus(1'b1, 8'hB0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hB1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hB2, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hBF;
    flush    = 1'b1;
    #1;
    checkOutput("flush_in_ready", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0;
    checkOutput("flush_occ", 32'(occupancy), 32'd0);
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_out_data", 32'(out_data), 32'(RST));
    for (int i = 0; i < DEPTH + 2; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("flush_no_out", 32'(out_valid), 32'd0);
    end

    // Random handshake with occasional flushes.
    $display("[TB] random");
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 299) == 0));
    end
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("final_drained", 32'(expq.size()), 32'd0);
    checkOutput("final_occ", 32'(occupancy), 32'd0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
